// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave with a data region and a reset-vector instruction region,
// programmable (fixed or LFSR-random) wait states, sticky error reporting and transfer counters.
module avalon_mem_slave #(
  parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
  parameter int          DATA_WORDS  = 1024,
  parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
  parameter int          INSTR_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter int          RANDOM_WAIT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int          DEPTH       = DATA_WORDS + INSTR_WORDS;
  localparam int          IDX_W       = $clog2(DEPTH);
  localparam logic [31:0] DATA_BYTES  = 32'(DATA_WORDS * 4);
  localparam logic [31:0] INSTR_BYTES = 32'(INSTR_WORDS * 4);

  localparam logic [2:0] E_RW_BOTH  = 3'd1;
  localparam logic [2:0] E_MISALIGN = 3'd2;
  localparam logic [2:0] E_UNMAPPED = 3'd3;
  localparam logic [2:0] E_CHANGED  = 3'd4;
  localparam logic [2:0] E_DROPPED  = 3'd5;

  // Galois form, taps 16,14,13,11 (mask 0xB400), shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] stall_target(input logic [15:0] s);
    if (RANDOM_WAIT != 0) return 16'(32'(s) % (WAIT_CYCLES + 1));
    else                  return 16'(WAIT_CYCLES);
  endfunction

  logic [31:0] mem [0:DEPTH-1];

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic [31:0] cap_addr_q;
  logic        cap_rd_q;
  logic        cap_wr_q;
  logic [31:0] cap_wd_q;
  logic [3:0]  cap_be_q;

  logic        req;
  logic        in_stall;
  logic        complete;
  logic        changed;
  logic        aborted;
  logic [31:0] eff_addr;
  logic        eff_rd;
  logic        eff_wr;
  logic [31:0] eff_wd;
  logic [3:0]  eff_be;
  logic [31:0] aligned;
  logic [31:0] d_off;
  logic [31:0] i_off;
  logic        d_hit;
  logic        i_hit;
  logic        mapped;
  logic [IDX_W-1:0] idx;
  logic        rd_ok;
  logic        wr_ok;
  logic [2:0]  new_code;

  assign req      = read | write;
  assign in_stall = (cnt_q != 16'd0);

  // Once a transfer has stalled, it is carried out with the values seen on its first cycle.
  assign eff_addr = in_stall ? cap_addr_q : address;
  assign eff_rd   = in_stall ? cap_rd_q   : read;
  assign eff_wr   = in_stall ? cap_wr_q   : write;
  assign eff_wd   = in_stall ? cap_wd_q   : writedata;
  assign eff_be   = in_stall ? cap_be_q   : byteenable;

  assign waitrequest = req && (cnt_q < tgt_q);
  assign complete    = req && (cnt_q == tgt_q) && !reset;
  assign aborted     = in_stall && !req;
  assign changed     = in_stall && req &&
                       ({address, read, write, writedata, byteenable} !=
                        {cap_addr_q, cap_rd_q, cap_wr_q, cap_wd_q, cap_be_q});

  assign aligned = {eff_addr[31:2], 2'b00};
  assign d_off   = aligned - DATA_BASE;
  assign i_off   = aligned - INSTR_BASE;
  assign d_hit   = (aligned >= DATA_BASE) && (d_off < DATA_BYTES);
  assign i_hit   = (aligned >= INSTR_BASE) && (i_off < INSTR_BYTES);
  assign mapped  = d_hit || i_hit;
  assign idx     = d_hit ? IDX_W'(d_off >> 2)
                         : IDX_W'(32'(DATA_WORDS) + (i_off >> 2));

  assign rd_ok = complete && eff_rd && !eff_wr;
  assign wr_ok = complete && eff_wr && !eff_rd;

  assign readdata = (rd_ok && mapped) ? mem[idx] : 32'h0000_0000;

  always_comb begin
    new_code = 3'd0;
    if (aborted)                     new_code = E_DROPPED;
    else if (changed)                new_code = E_CHANGED;
    else if (complete) begin
      if (eff_rd && eff_wr)          new_code = E_RW_BOTH;
      else if (eff_addr[1:0] != 2'b00) new_code = E_MISALIGN;
      else if (!mapped)              new_code = E_UNMAPPED;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    lfsr_d     = lfsr_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;

    if (!req || complete) cnt_d = 16'd0;
    else if (waitrequest) cnt_d = cnt_q + 16'd1;

    if (complete) begin
      lfsr_d = lfsr_next(lfsr_q);
      tgt_d  = stall_target(lfsr_d);
    end

    if (rd_ok) rd_count_d = rd_count_q + 16'd1;
    if (wr_ok) wr_count_d = wr_count_q + 16'd1;

    // Only the first error since reset is recorded.
    if (!err_q && (new_code != 3'd0)) begin
      err_d      = 1'b1;
      err_code_d = new_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 16'd0;
      tgt_q      <= stall_target(LFSR_SEED);
      lfsr_q     <= LFSR_SEED;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      lfsr_q     <= lfsr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req && !in_stall && waitrequest) begin
      cap_addr_q <= address;
      cap_rd_q   <= read;
      cap_wr_q   <= write;
      cap_wd_q   <= writedata;
      cap_be_q   <= byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && mapped) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem[idx][8*b +: 8] <= eff_wd[8*b +: 8];
      end
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Scoreboard bench for avalon_mem_slave: five instances with different wait-state setups,
// a driver issuing directed transfers and a negedge monitor checking every completion.
module tb_avalon_mem_slave;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s [NI];
  logic [31:0] address [NI];
  logic        read_s  [NI];
  logic        write_s [NI];
  logic [31:0] wdata   [NI];
  logic [3:0]  be_s    [NI];
  logic        waitreq [NI];
  logic [31:0] rdata   [NI];
  logic        err_s   [NI];
  logic [2:0]  ecode   [NI];
  logic [15:0] rdcnt   [NI];
  logic [15:0] wrcnt   [NI];

  avalon_mem_slave #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset_s[0]), .address(address[0]), .read(read_s[0]), .write(write_s[0]),
    .writedata(wdata[0]), .byteenable(be_s[0]), .waitrequest(waitreq[0]), .readdata(rdata[0]),
    .err(err_s[0]), .err_code(ecode[0]), .rd_count(rdcnt[0]), .wr_count(wrcnt[0]));
  avalon_mem_slave #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(reset_s[1]), .address(address[1]), .read(read_s[1]), .write(write_s[1]),
    .writedata(wdata[1]), .byteenable(be_s[1]), .waitrequest(waitreq[1]), .readdata(rdata[1]),
    .err(err_s[1]), .err_code(ecode[1]), .rd_count(rdcnt[1]), .wr_count(wrcnt[1]));
  avalon_mem_slave #(.WAIT_CYCLES(4)) u2 (
    .clk(clk), .reset(reset_s[2]), .address(address[2]), .read(read_s[2]), .write(write_s[2]),
    .writedata(wdata[2]), .byteenable(be_s[2]), .waitrequest(waitreq[2]), .readdata(rdata[2]),
    .err(err_s[2]), .err_code(ecode[2]), .rd_count(rdcnt[2]), .wr_count(wrcnt[2]));
  avalon_mem_slave #(.WAIT_CYCLES(7), .RANDOM_WAIT(1)) u3 (
    .clk(clk), .reset(reset_s[3]), .address(address[3]), .read(read_s[3]), .write(write_s[3]),
    .writedata(wdata[3]), .byteenable(be_s[3]), .waitrequest(waitreq[3]), .readdata(rdata[3]),
    .err(err_s[3]), .err_code(ecode[3]), .rd_count(rdcnt[3]), .wr_count(wrcnt[3]));
  avalon_mem_slave #(.WAIT_CYCLES(2)) u4 (
    .clk(clk), .reset(reset_s[4]), .address(address[4]), .read(read_s[4]), .write(write_s[4]),
    .writedata(wdata[4]), .byteenable(be_s[4]), .waitrequest(waitreq[4]), .readdata(rdata[4]),
    .err(err_s[4]), .err_code(ecode[4]), .rd_count(rdcnt[4]), .wr_count(wrcnt[4]));

  typedef struct {
    int          k;
    bit          chk_rd;
    logic [31:0] rd;
    int          stall;   // -1: random stall, only range-checked
  } item_t;

  item_t sbq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    stall_n [NI];
  int    hist [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every completing cycle pops one expected response.
  initial begin
    item_t it;
    for (int k = 0; k < NI; k++) stall_n[k] = 0;
    for (int v = 0; v < 8; v++) hist[v] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (reset_s[k] || !(read_s[k] || write_s[k])) begin
          stall_n[k] = 0;
        end else if (waitreq[k]) begin
          stall_n[k]++;
        end else begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_completion: instance %0d completed with no expected item", k);
          end else begin
            it = sbq.pop_front();
            chk("completion_instance", k, it.k);
            if (it.chk_rd) chk("readdata", rdata[k], it.rd);
            if (it.stall >= 0) begin
              chk("stall_cycles", stall_n[k], it.stall);
            end else begin
              chk("random_stall_in_range", 32'(stall_n[k] <= 7), 32'd1);
              if (stall_n[k] <= 7) hist[stall_n[k]]++;
            end
          end
          stall_n[k] = 0;
        end
      end
    end
  end

  task automatic wait_done(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitreq[k] && n < 64);
    if (waitreq[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: instance %0d still stalling after %0d cycles", k, n);
    end
  endtask

  task automatic xfer(input int k, input logic [31:0] a, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input bit chk_rd, input logic [31:0] exp_rd, input int exp_stall);
    item_t it;
    it.k = k; it.chk_rd = chk_rd; it.rd = exp_rd; it.stall = exp_stall;
    sbq.push_back(it);
    address[k] = a; read_s[k] = rd; write_s[k] = wr; wdata[k] = wd; be_s[k] = be;
    wait_done(k);
    @(posedge clk); #1;
    read_s[k] = 1'b0; write_s[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, input int st);
    xfer(k, a, 1'b0, 1'b1, d, be, 1'b0, 32'h0, st);
  endtask

  task automatic rdx(input int k, input logic [31:0] a, input logic [31:0] exp, input int st);
    xfer(k, a, 1'b1, 1'b0, 32'h0, 4'hF, 1'b1, exp, st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      reset_s[k] = 1'b1; address[k] = 32'h0; read_s[k] = 1'b0; write_s[k] = 1'b0;
      wdata[k] = 32'h0; be_s[k] = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) reset_s[k] = 1'b0;

    for (int k = 0; k < NI; k++) begin
      chk("reset_err", err_s[k], 1'b0);
      chk("reset_err_code", ecode[k], 3'd0);
      chk("reset_rd_count", rdcnt[k], 16'd0);
      chk("reset_wr_count", wrcnt[k], 16'd0);
      chk("idle_waitrequest", waitreq[k], 1'b0);
    end

    // Zero-wait instance: data, instruction, byte lanes, boundaries, unmapped, read+write.
    wr(0, 32'd400, 32'd123, 4'hF, 0);
    rdx(0, 32'd400, 32'd123, 0);
    chk("u0_rd_count_1", rdcnt[0], 16'd1);
    wr(0, 32'hBFC0_0000, 32'h8C01_0064, 4'hF, 0);
    rdx(0, 32'hBFC0_0000, 32'h8C01_0064, 0);
    wr(0, 32'h10, 32'hFFFF_FFFF, 4'hF, 0);
    wr(0, 32'h10, 32'hAABB_CCDD, 4'b1010, 0);
    rdx(0, 32'h10, 32'hAAFF_CCFF, 0);
    wr(0, 32'h10, 32'h0000_0000, 4'b0000, 0);
    rdx(0, 32'h10, 32'hAAFF_CCFF, 0);
    chk("u0_wr_count_be0", wrcnt[0], 16'd5);
    wr(0, 32'h0000_0FFC, 32'h55, 4'hF, 0);
    rdx(0, 32'h0000_0FFC, 32'h55, 0);
    wr(0, 32'hBFC0_0FFC, 32'h66, 4'hF, 0);
    rdx(0, 32'hBFC0_0FFC, 32'h66, 0);
    chk("u0_err_clean", err_s[0], 1'b0);
    rdx(0, 32'h4000_0000, 32'h0, 0);
    chk("u0_unmapped_err", err_s[0], 1'b1);
    chk("u0_unmapped_code", ecode[0], 3'd3);
    rdx(0, 32'h0000_1000, 32'h0, 0);
    rdx(0, 32'hBFBF_FFFC, 32'h0, 0);
    chk("u0_rd_count_9", rdcnt[0], 16'd9);
    xfer(0, 32'd400, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 0);
    chk("u0_rw_code_kept", ecode[0], 3'd3);
    chk("u0_rw_no_rd_count", rdcnt[0], 16'd9);
    chk("u0_rw_no_wr_count", wrcnt[0], 16'd7);
    rdx(0, 32'd400, 32'd123, 0);

    // Fixed three-wait instance: lane write, back-to-back reads, misaligned read.
    wr(1, 32'h200, 32'hFFFF_FFFF, 4'hF, 3);
    wr(1, 32'h200, 32'h1234_5678, 4'b0011, 3);
    chk("u1_wr_count", wrcnt[1], 16'd2);   // preload write plus the lane write
    rdx(1, 32'h200, 32'hFFFF_5678, 3);
    rdx(1, 32'h200, 32'hFFFF_5678, 3);
    chk("u1_rd_count", rdcnt[1], 16'd2);
    chk("u1_err_clean", err_s[1], 1'b0);
    rdx(1, 32'h202, 32'hFFFF_5678, 3);
    chk("u1_misalign_err", err_s[1], 1'b1);
    chk("u1_misalign_code", ecode[1], 3'd2);

    // Four-wait instance: dropped request, then reset in the middle of a write.
    wr(2, 32'h40, 32'h1111_2222, 4'hF, 4);
    rdx(2, 32'h40, 32'h1111_2222, 4);
    address[2] = 32'h40; read_s[2] = 1'b1; be_s[2] = 4'hF;
    repeat (2) @(posedge clk);
    #1 read_s[2] = 1'b0;
    @(posedge clk); #1;
    chk("u2_drop_err", err_s[2], 1'b1);
    chk("u2_drop_code", ecode[2], 3'd5);
    chk("u2_drop_rd_count", rdcnt[2], 16'd1);
    rdx(2, 32'h40, 32'h1111_2222, 4);
    chk("u2_rd_count_after_drop", rdcnt[2], 16'd2);
    address[2] = 32'h40; write_s[2] = 1'b1; wdata[2] = 32'h0; be_s[2] = 4'hF;
    repeat (2) @(posedge clk);
    #1 reset_s[2] = 1'b1;
    @(posedge clk);
    #1 reset_s[2] = 1'b0; write_s[2] = 1'b0;
    chk("u2_reset_err", err_s[2], 1'b0);
    chk("u2_reset_code", ecode[2], 3'd0);
    chk("u2_reset_wr_count", wrcnt[2], 16'd0);
    rdx(2, 32'h40, 32'h1111_2222, 4);
    chk("u2_rd_count_after_reset", rdcnt[2], 16'd1);

    // Two-wait instance: address changes while stalled.
    wr(4, 32'h40, 32'hCAFE_F00D, 4'hF, 2);
    wr(4, 32'h44, 32'hCAFE_F00D, 4'hF, 2);
    begin
      item_t it;
      it.k = 4; it.chk_rd = 1'b1; it.rd = 32'hCAFE_F00D; it.stall = 2;
      sbq.push_back(it);
    end
    address[4] = 32'h40; read_s[4] = 1'b1; be_s[4] = 4'hF;
    @(posedge clk);
    #1 address[4] = 32'h44;
    wait_done(4);
    @(posedge clk);
    #1 read_s[4] = 1'b0;
    chk("u4_change_err", err_s[4], 1'b1);
    chk("u4_change_code", ecode[4], 3'd4);

    // Random-wait instance: 1000 reads over eight preloaded words.
    for (int i = 0; i < 8; i++) wr(3, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, -1);
    for (int i = 0; i < 1000; i++) rdx(3, 32'((i % 8) * 4), 32'hA500_0000 | 32'(i % 8), -1);
    chk("u3_rd_count", rdcnt[3], 16'd1000);
    for (int v = 0; v < 8; v++) chk("random_stall_value_seen", 32'(hist[v] > 0), 32'd1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
